// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, keeps at most one imem request in
// flight, and buffers returned {pc, inst} pairs in a small queue for the decoder.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned     FQ_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_inst_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FQ_FULL = CNT_W'(FQ_DEPTH);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_STALL
  } state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]    req_pc_q;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0]    fq_pc_q   [FQ_DEPTH];
  logic [31:0]        fq_inst_q [FQ_DEPTH];

  logic req_hs;
  logic rsp_take;
  logic push;
  logic pop;
  logic unused_redirect_lsb;

  // Target's low bits are ignored: fetch addresses are always word aligned.
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  assign imem_req_valid_o = (state_q == S_REQ);
  assign imem_req_addr_o  = fetch_pc_q;
  assign req_hs           = imem_req_valid_o && imem_req_ready_i;
  assign rsp_take         = (state_q == S_WAIT) && imem_rsp_valid_i;
  // A response arriving alongside a redirect belongs to the old path.
  assign push             = rsp_take && !drop_q && !redirect_i;

  assign inst_valid_o = (count_q != '0) && !redirect_i;
  assign pop          = inst_valid_o && inst_ready_i;
  assign inst_o       = fq_inst_q[rd_ptr_q];
  assign inst_pc_o    = fq_pc_q[rd_ptr_q];

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // count_d already reflects a redirect flush, so a redirect in WAIT (with
  // response) or STALL falls through to REQ without a special case.
  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      S_REQ: begin
        if (req_hs) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          drop_d  = 1'b0;
          state_d = (count_d < FQ_FULL) ? S_REQ : S_STALL;
        end
      end
      S_STALL: begin
        if (count_d < FQ_FULL) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (req_hs) fetch_pc_d = fetch_pc_q + XLEN'(4);

    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      if (req_hs || ((state_q == S_WAIT) && !imem_rsp_valid_i)) drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Payload storage carries no reset; count_q alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (req_hs) req_pc_q <= fetch_pc_q;
    if (push) begin
      fq_pc_q[wr_ptr_q]   <= req_pc_q;
      fq_inst_q[wr_ptr_q] <= imem_rsp_inst_i;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a variable-latency imem model feeds the DUT
// and expected {pc, inst} pairs are queued at response time, popped at decode.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          FQ_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_inst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_inst_i  (imem_rsp_inst_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t sb[$];

  int checks = 0;
  int errors = 0;

  // stimulus knobs for the next cycle
  bit          mem_ready;
  bit          dec_ready;
  bit          redir;
  logic [31:0] redir_pc;
  int          k_lat;
  bit          k_rand;

  // memory / fetch model state
  bit          out_busy;
  bit          out_stale;
  int          out_cnt;
  logic [31:0] out_addr;
  logic [31:0] exp_pc;
  int          hs_count;
  int          pop_count;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    sb.delete();
    out_busy  = 1'b0;
    out_stale = 1'b0;
    out_cnt   = 0;
    exp_pc    = RESET_PC;
  endtask

  task automatic idle_inputs();
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_inst_i  = 32'h0;
    redirect_i       = 1'b0;
    redirect_pc_i    = 32'h0;
    inst_ready_i     = 1'b0;
    mem_ready = 1'b0; dec_ready = 1'b0; redir = 1'b0; redir_pc = 32'h0;
    k_lat = 1; k_rand = 1'b0;
  endtask

  // One clock cycle: drive at negedge, sample and check mid-cycle, then
  // advance the model to what the next rising edge must produce.
  task automatic step();
    bit     exp_req, exp_valid, hs, rsp;
    entry_t head, e;
    @(negedge clk);
    rsp = out_busy && (out_cnt == 1);
    imem_req_ready_i = mem_ready;
    imem_rsp_valid_i = rsp;
    imem_rsp_inst_i  = rsp ? inst_of(out_addr) : $urandom();
    redirect_i       = redir;
    redirect_pc_i    = redir_pc;
    inst_ready_i     = dec_ready;
    #1;
    exp_req = !out_busy && (sb.size() < FQ_DEPTH);
    checks++;
    if (imem_req_valid_o !== exp_req) begin
      errors++; $display("FAIL req_valid t=%0t got=%b exp=%b", $time, imem_req_valid_o, exp_req);
    end
    if (exp_req) begin
      checks++;
      if (imem_req_addr_o !== exp_pc) begin
        errors++; $display("FAIL req_addr t=%0t got=%h exp=%h", $time, imem_req_addr_o, exp_pc);
      end
    end
    exp_valid = (sb.size() != 0) && !redir;
    checks++;
    if (inst_valid_o !== exp_valid) begin
      errors++; $display("FAIL inst_valid t=%0t got=%b exp=%b", $time, inst_valid_o, exp_valid);
    end
    if (exp_valid) begin
      head = sb[0];
      checks++;
      if ((inst_pc_o !== head.pc) || (inst_o !== head.inst)) begin
        errors++;
        $display("FAIL head t=%0t got pc=%h inst=%h exp pc=%h inst=%h",
                 $time, inst_pc_o, inst_o, head.pc, head.inst);
      end
      if (dec_ready) begin
        void'(sb.pop_front());
        pop_count++;
      end
    end
    if (redir) sb.delete();
    if (rsp) begin
      if (!out_stale && !redir) begin
        e.pc = out_addr; e.inst = inst_of(out_addr);
        sb.push_back(e);
      end
      out_busy = 1'b0;
    end else if (out_busy) begin
      out_cnt--;
      if (redir) out_stale = 1'b1;
    end
    hs = exp_req && mem_ready;
    if (hs) begin
      out_busy  = 1'b1;
      out_addr  = exp_pc;
      out_stale = redir;
      out_cnt   = k_rand ? int'($urandom_range(1, 4)) : k_lat;
      hs_count++;
    end
    if (redir)   exp_pc = {redir_pc[31:2], 2'b00};
    else if (hs) exp_pc = exp_pc + 32'd4;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (imem_req_valid_o !== 1'b1) begin errors++; $display("FAIL rst_req_valid got=%b exp=1", imem_req_valid_o); end
    checks++; if (imem_req_addr_o !== RESET_PC) begin errors++; $display("FAIL rst_req_addr got=%h exp=%h", imem_req_addr_o, RESET_PC); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid_o); end
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (imem_req_valid_o !== 1'b1) begin errors++; $display("FAIL post_rst_req_valid got=%b exp=1", imem_req_valid_o); end
    checks++; if (imem_req_addr_o !== RESET_PC) begin errors++; $display("FAIL post_rst_req_addr got=%h exp=%h", imem_req_addr_o, RESET_PC); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL post_rst_inst_valid got=%b exp=0", inst_valid_o); end
  endtask

  task automatic test_stream();
    do_reset();
    mem_ready = 1'b1; dec_ready = 1'b1; k_lat = 1;
    pop_count = 0;
    for (int s = 0; s < 20; s++) begin
      step();
      if (s == 0) begin
        checks++; if (imem_req_addr_o !== 32'h8000_0000) begin errors++; $display("FAIL stream_addr0 got=%h exp=80000000", imem_req_addr_o); end
      end
      if (s == 2) begin
        checks++; if (imem_req_addr_o !== 32'h8000_0004) begin errors++; $display("FAIL stream_addr1 got=%h exp=80000004", imem_req_addr_o); end
        checks++; if (inst_pc_o !== 32'h8000_0000) begin errors++; $display("FAIL stream_pc0 got=%h exp=80000000", inst_pc_o); end
      end
      if (s == 4) begin
        checks++; if (imem_req_addr_o !== 32'h8000_0008) begin errors++; $display("FAIL stream_addr2 got=%h exp=80000008", imem_req_addr_o); end
        checks++; if (inst_pc_o !== 32'h8000_0004) begin errors++; $display("FAIL stream_pc1 got=%h exp=80000004", inst_pc_o); end
      end
    end
    checks++; if (pop_count != 9) begin errors++; $display("FAIL stream_throughput got=%0d exp=9", pop_count); end
  endtask

  task automatic test_stall();
    do_reset();
    mem_ready = 1'b1; dec_ready = 1'b0; k_lat = 1;
    for (int s = 0; s < 10; s++) step();
    checks++; if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL stall_req_valid got=%b exp=0", imem_req_valid_o); end
    checks++; if (inst_pc_o !== 32'h8000_0000) begin errors++; $display("FAIL stall_head_pc got=%h exp=80000000", inst_pc_o); end
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    step();
    checks++; if (imem_req_valid_o !== 1'b1) begin errors++; $display("FAIL stall_resume_valid got=%b exp=1", imem_req_valid_o); end
    checks++; if (imem_req_addr_o !== 32'h8000_0010) begin errors++; $display("FAIL stall_resume_addr got=%h exp=80000010", imem_req_addr_o); end
    dec_ready = 1'b1;
    for (int s = 0; s < 12; s++) step();
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_ready = 1'b1; dec_ready = 1'b0; k_lat = 1;
    step();
    k_lat = 3;
    step();
    step();
    step();
    redir = 1'b1; redir_pc = 32'h8000_0103;
    step();
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rdw_valid_in_redirect got=%b exp=0", inst_valid_o); end
    redir = 1'b0;
    step();
    checks++; if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL rdw_wait_stale got=%b exp=0", imem_req_valid_o); end
    step();
    checks++; if (imem_req_addr_o !== 32'h8000_0100) begin errors++; $display("FAIL rdw_new_addr got=%h exp=80000100", imem_req_addr_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rdw_queue_empty got=%b exp=0", inst_valid_o); end
    dec_ready = 1'b1; k_lat = 1;
    for (int s = 0; s < 6; s++) step();
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    mem_ready = 1'b1; dec_ready = 1'b1; k_lat = 2;
    redir = 1'b1; redir_pc = 32'h8000_0200;
    step();
    redir = 1'b0;
    step();
    step();
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rdh_dropped got=%b exp=0", inst_valid_o); end
    k_lat = 1;
    step();
    checks++; if (imem_req_addr_o !== 32'h8000_0200) begin errors++; $display("FAIL rdh_target got=%h exp=80000200", imem_req_addr_o); end
    redir = 1'b1; redir_pc = 32'h8000_0300;
    step();
    redir = 1'b0;
    step();
    checks++; if (imem_req_valid_o !== 1'b1) begin errors++; $display("FAIL rdr_req_next got=%b exp=1", imem_req_valid_o); end
    checks++; if (imem_req_addr_o !== 32'h8000_0300) begin errors++; $display("FAIL rdr_target got=%h exp=80000300", imem_req_addr_o); end
    step();
    step();
    checks++; if (inst_pc_o !== 32'h8000_0300) begin errors++; $display("FAIL rdr_head_pc got=%h exp=80000300", inst_pc_o); end
    for (int s = 0; s < 4; s++) step();
  endtask

  task automatic test_ready_low();
    int hs0;
    do_reset();
    mem_ready = 1'b0; dec_ready = 1'b1; k_lat = 1;
    hs0 = hs_count;
    for (int s = 0; s < 5; s++) begin
      redir = (s == 2); redir_pc = 32'h8000_0400;
      step();
      if (s == 1) begin
        checks++; if (imem_req_addr_o !== 32'h8000_0000) begin errors++; $display("FAIL rl_addr_before got=%h exp=80000000", imem_req_addr_o); end
      end
      if (s == 3) begin
        checks++; if (imem_req_addr_o !== 32'h8000_0400) begin errors++; $display("FAIL rl_addr_after got=%h exp=80000400", imem_req_addr_o); end
      end
    end
    redir = 1'b0; mem_ready = 1'b1;
    step();
    step();
    checks++; if (hs_count - hs0 != 1) begin errors++; $display("FAIL rl_handshakes got=%0d exp=1", hs_count - hs0); end
    step();
    checks++; if (inst_pc_o !== 32'h8000_0400) begin errors++; $display("FAIL rl_head_pc got=%h exp=80000400", inst_pc_o); end
    for (int s = 0; s < 4; s++) step();
  endtask

  task automatic test_wrap();
    do_reset();
    mem_ready = 1'b0; dec_ready = 1'b1; k_lat = 1;
    redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
    step();
    redir = 1'b0; mem_ready = 1'b1;
    step();
    checks++; if (imem_req_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr_top got=%h exp=fffffffc", imem_req_addr_o); end
    step();
    step();
    checks++; if (imem_req_addr_o !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr_zero got=%h exp=00000000", imem_req_addr_o); end
    checks++; if (inst_pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_head_pc got=%h exp=fffffffc", inst_pc_o); end
    for (int s = 0; s < 4; s++) step();
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_ready = 1'b1; dec_ready = 1'b0; k_lat = 1;
    step();
    k_lat = 5;
    step();
    step();
    step();
    checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got=%b exp=1", inst_valid_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (imem_req_valid_o !== 1'b1) begin errors++; $display("FAIL ar_req_valid got=%b exp=1", imem_req_valid_o); end
    checks++; if (imem_req_addr_o !== RESET_PC) begin errors++; $display("FAIL ar_req_addr got=%h exp=%h", imem_req_addr_o, RESET_PC); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL ar_inst_valid got=%b exp=0", inst_valid_o); end
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    mem_ready = 1'b1; dec_ready = 1'b1; k_lat = 1;
    for (int s = 0; s < 6; s++) step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    k_rand = 1'b1;
    for (int s = 0; s < 400; s++) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      dec_ready = ($urandom_range(0, 2) != 0);
      redir     = ($urandom_range(0, 15) == 0);
      redir_pc  = $urandom();
      step();
    end
    redir = 1'b0; dec_ready = 1'b1; mem_ready = 1'b1;
    for (int s = 0; s < 20; s++) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hs_count  = 0;
    pop_count = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_coincident();
    test_ready_low();
    test_wrap();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch unit for the multi-cycle/pipelined core. It owns the architectural fetch PC and issues requests to an instruction memory with variable latency through a valid/ready request channel and a valid response channel. Fetched {pc, inst} pairs are buffered in an internal fetch queue of configurable depth and handed to the decoder through a valid/ready handshake. It replaces the combinational PC register and next-PC adder of the single-cycle top; branch/jump targets now arrive as redirects from the execute stage.

## Interface
- XLEN, 32, PC and address width
- RESET_PC, 32'h8000_0000 (XLEN bits), first fetch address after reset
- FQ_DEPTH, 4, fetch queue entries; power of two, >= 2

- clk_i  in  1  clock, all state updates on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- imem_req_valid_o  out  1  fetch request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  XLEN  fetch address, word aligned
- imem_rsp_valid_i  in  1  instruction word returned
- imem_rsp_inst_i  in  32  returned instruction
- redirect_i  in  1  control-flow redirect from execute
- redirect_pc_i  in  XLEN  redirect target
- inst_valid_o  out  1  queue head valid
- inst_ready_i  in  1  decoder accepts head
- inst_o  out  32  head instruction
- inst_pc_o  out  XLEN  head PC

## Operation
- State: fetch_pc (XLEN), FSM {REQ, WAIT, STALL}, drop flag, queue with rd/wr pointers and count (clog2(FQ_DEPTH)+1 bits).
- At most one request outstanding. imem_req_valid_o = (state == REQ); imem_req_addr_o = fetch_pc. Memory samples the address only at handshake, so the address may change while valid is pending (retarget by redirect).
- REQ: on req handshake -> WAIT, fetch_pc <= fetch_pc + 4 (wraps modulo 2^XLEN).
- WAIT: on imem_rsp_valid_i: if drop=0 push {pc_of_request, inst}; clear drop; -> REQ if count after push < FQ_DEPTH, else STALL. pc_of_request is fetch_pc - 4, held in a request-PC register.
- STALL: -> REQ when count < FQ_DEPTH (a pop occurred).
- Pop: inst_valid_o = (count != 0) && !redirect_i; pop on inst_valid_o && inst_ready_i. Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority, any state): queue flushed (count, pointers to 0); fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00}.
  - REQ without handshake: stay REQ, request retargeted next cycle.
  - REQ with handshake same cycle: -> WAIT, drop <= 1 (response discarded); fetch_pc gets redirect target, not +4.
  - WAIT: drop <= 1 if response not present this cycle; if response present this cycle it is discarded and FSM -> REQ.
  - STALL: -> REQ.
- Dropped responses never enter the queue and never update fetch_pc.
- Queue never overflows: REQ is entered only with count < FQ_DEPTH, and count grows only in WAIT.

## Timing
- Reset values: state=REQ, fetch_pc=RESET_PC, drop=0, count=0; hence imem_req_valid_o=1, imem_req_addr_o=RESET_PC, inst_valid_o=0 during and immediately after reset.
- Reset mid-transaction: all state cleared asynchronously; any later response arriving for the pre-reset request is a memory protocol violation (memory is reset together).
- Latency: request handshake at cycle t, response at t+k (k >= 1); entry visible on inst_valid_o at t+k+1.
- Throughput with k=1 and decoder always ready: one instruction per 2 cycles.
- Redirect at cycle t: inst_valid_o low in cycle t; new-target request valid in cycle t+1 (or t+1 after the stale response returns when an outstanding request exists).
- No combinational path from imem_rsp_* to any output; redirect_i -> inst_valid_o is the only combinational input-to-output path.

## Test plan
- Reset release, memory ready always, k=1, decoder ready: request addresses 8000_0000, 8000_0004, 8000_0008; inst_pc_o matches each, instructions in order.
- Decoder ready=0, FQ_DEPTH=4: after 4 responses FSM in STALL, imem_req_valid_o=0, count=4; one pop -> request for 8000_0010 next cycle.
- Redirect to 8000_0103 while in WAIT (k=3): stale response discarded, next request addr 8000_0100, queue empty, inst_valid_o=0 in redirect cycle.
- Redirect coincident with request handshake: response of that request dropped, next request at redirect target; redirect coincident with response in WAIT: response dropped, REQ next cycle.
- Memory ready held low 5 cycles, redirect in cycle 3: imem_req_addr_o switches to target, single handshake at target, no stale drop.
- fetch_pc = FFFF_FFFC (via redirect): following request addr 0000_0000; async reset asserted mid-WAIT returns all outputs to reset values immediately.
